// File: rtl/axis_tpseq_pkg.sv
// Shared types and helpers for the AXI-Stream test-pattern burst sequencer.
package axis_tpseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Counter width able to hold 0..len-1, never narrower than one bit.
  function automatic int cnt_width(input int len);
    return $clog2(len > 1 ? len : 2);
  endfunction

endpackage

// File: rtl/tpseq_counter.sv
// Loadable up-counter with terminal-count flag and asynchronous active-low clear.
module tpseq_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == terminal);

endmodule

// File: rtl/axis_testpattern_sequencer.sv
// Burst scheduler gating a test-pattern generator's AXI-Stream into fixed bursts and gaps.
// Optional m_axis_tlast output is enabled by defining AXIS_TPSEQ_TLAST_EN.
module axis_testpattern_sequencer
  import axis_tpseq_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 8,
  parameter int NUM_BURSTS = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  start,
  input  logic                  stop,
  output logic                  gen_enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
`ifdef AXIS_TPSEQ_TLAST_EN
  output logic                  m_axis_tlast,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  localparam int BEAT_W = cnt_width(BURST_LEN);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);
  localparam logic [BEAT_W-1:0]    BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] RUN_LEN   = CNT_WIDTH'(NUM_BURSTS);

  state_t state, state_next;
  logic   done_next;
  logic   stop_pending;
  logic   in_burst;
  logic   beat_accept;
  logic   beat_tc;
  logic   gap_tc;
  logic   burst_end;
  logic   start_run;
  logic   stop_req;
  logic   run_complete;
  logic [CNT_WIDTH-1:0] burst_next;

  assign in_burst      = (state == ST_BURST);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = s_axis_tvalid & in_burst;
  assign s_axis_tready = m_axis_tready & in_burst;
  assign busy          = (state != ST_IDLE);

`ifdef AXIS_TPSEQ_TLAST_EN
  assign m_axis_tlast = in_burst & s_axis_tvalid & beat_tc;
`endif

  assign beat_accept  = s_axis_tvalid & s_axis_tready;
  assign burst_end    = beat_accept & beat_tc;
  assign start_run    = (state == ST_IDLE) & start & ~stop;
  // A stop arriving on the very cycle of a burst boundary is honoured immediately.
  assign stop_req     = stop_pending | stop;
  assign burst_next   = burst_count + 1'b1;
  assign run_complete = (NUM_BURSTS != 0) && (burst_next == RUN_LEN);

  tpseq_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
    .clk        (m_axis_aclk),
    .rst_n      (m_axis_aresetn),
    .load       (start_run | burst_end),
    .load_value ('0),
    .inc        (beat_accept),
    .terminal   (BEAT_LAST),
    .tc         (beat_tc)
  );

  // Gap counter is held at zero outside GAP so each gap starts fresh.
  tpseq_counter #(.WIDTH(GAP_W)) u_gap_cnt (
    .clk        (m_axis_aclk),
    .rst_n      (m_axis_aresetn),
    .load       (state != ST_GAP),
    .load_value ('0),
    .inc        (state == ST_GAP),
    .terminal   (GAP_LAST),
    .tc         (gap_tc)
  );

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_run) state_next = ST_BURST;
      end
      ST_BURST: begin
        if (burst_end) begin
          if (stop_req || run_complete) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_req) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (gap_tc) begin
          state_next = ST_BURST;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state        <= ST_IDLE;
      gen_enable   <= 1'b0;
      done         <= 1'b0;
      burst_count  <= '0;
      stop_pending <= 1'b0;
    end else begin
      state      <= state_next;
      gen_enable <= (state_next == ST_BURST);
      done       <= done_next;
      if (start_run) begin
        burst_count <= '0;
      end else if (burst_end) begin
        burst_count <= burst_next;
      end
      if (state_next == ST_IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop && state != ST_IDLE) begin
        stop_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_testpattern_sequencer.md
# axis_testpattern_sequencer

Burst scheduler for `axis_testpattern_generator`: drives the generator's `enable` and gates its AXI-Stream output so that downstream sees fixed-length bursts separated by idle gaps, repeated a programmed number of times. Sits between the generator's master port and the downstream consumer, for example a DAC FSM. It is used to exercise downstream blocks with framed, bursty traffic instead of a continuous counter stream.

## Interface
- `DATA_WIDTH`, 24: tdata width; matches `M00_AXIS_DATA_WIDTH` of the generator.
- `BURST_LEN`, 16: accepted beats per burst; must be ≥1.
- `GAP_CYCLES`, 8: idle clock cycles between bursts; 0 allowed.
- `NUM_BURSTS`, 0: bursts per run; 0 means run until stopped.
- `CNT_WIDTH`, 16: width of `burst_count`.

Ports:
- `m_axis_aclk` in 1: single clock.
- `m_axis_aresetn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; starts a run from IDLE.
- `stop` in 1: one-cycle pulse; requests the end of the run at the next burst boundary.
- `gen_enable` out 1: enable for the generator; registered.
- `s_axis_tdata` in DATA_WIDTH: data from the generator.
- `s_axis_tvalid` in 1: valid from the generator.
- `s_axis_tready` out 1: ready to the generator.
- `m_axis_tdata` out DATA_WIDTH: data to downstream.
- `m_axis_tvalid` out 1: valid to downstream.
- `m_axis_tready` in 1: ready from downstream.
- `m_axis_tlast` out 1: last beat of a burst; present only with `AXIS_TPSEQ_TLAST_EN`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `burst_count` out CNT_WIDTH: completed bursts in the current run.

## Operation
- States: IDLE, BURST, GAP.
- IDLE:
  - `start` and no `stop` → BURST.
  - `start` together with `stop` → stay IDLE; stop wins.
  - On entry to BURST, clear `burst_count` and the beat counter.
- BURST:
  - Datapath is combinational pass-through: `m_axis_tdata = s_axis_tdata`, `m_axis_tvalid = s_axis_tvalid & (state==BURST)`, `s_axis_tready = m_axis_tready & (state==BURST)`.
  - A beat is accepted when `s_axis_tvalid & s_axis_tready`; each accepted beat increments the beat counter.
  - After beat `BURST_LEN-1` is accepted, increment `burst_count` and reset the beat counter. Next state:
    - IDLE, with a `done` pulse, if a stop is pending or `burst_count+1 == NUM_BURSTS` (NUM_BURSTS ≠ 0).
    - Otherwise GAP if GAP_CYCLES > 0, else BURST.
- GAP:
  - Counts GAP_CYCLES cycles, then → BURST.
  - If a stop is pending → IDLE next cycle, with a `done` pulse.
- `stop` pulse in BURST or GAP sets a sticky pending flag. The flag clears on entering IDLE. `stop` in IDLE without `start` is ignored.
- `start` outside IDLE is ignored.
- `gen_enable` is 1 only in BURST.
- A word the generator holds valid while `gen_enable` is low stays unaccepted (tready low) and is the first beat of the next burst; no data is lost or duplicated.
- `burst_count` wraps modulo 2^CNT_WIDTH when NUM_BURSTS = 0.
- Reset values: state IDLE, `gen_enable` 0, `busy` 0, `done` 0, `burst_count` 0, counters 0, stop-pending 0. The combinational outputs `m_axis_tvalid`, `s_axis_tready` and `m_axis_tlast` are therefore 0.
- Reset asserted mid-burst: return immediately to IDLE. The partial burst is abandoned, with no `done` and no `tlast`.

## Timing
- `start` sampled at edge N: state BURST and `gen_enable` = 1 from N+1. The first beat can be accepted in cycle N+1 if the source is already valid.
- Last beat accepted at edge M: GAP (or IDLE/BURST) from M+1. At M+1, `gen_enable` = 0 and `s_axis_tready` = 0.
- Gap length is exactly GAP_CYCLES cycles with tvalid low. The next burst's `gen_enable` rises at M+1+GAP_CYCLES.
- `done` is high exactly during cycle M+1 when ending from BURST, or the cycle after the stop-pending GAP exit.
- Pass-through adds zero latency. The AXIS rule is kept: `m_axis_tvalid` never depends on `m_axis_tready`.

## Configuration
- `AXIS_TPSEQ_TLAST_EN` defined:
  - `m_axis_tlast` port exists.
  - `m_axis_tlast = (state==BURST) & (beat_cnt == BURST_LEN-1)`, qualified like tvalid.
- `AXIS_TPSEQ_TLAST_EN` undefined:
  - No `m_axis_tlast` port.
  - Burst framing is visible only through `gen_enable` and `burst_count`.

## Structure
- Shared package/header `axis_tpseq_pkg`:
  - State encodings `ST_IDLE` = 0, `ST_BURST` = 1, `ST_GAP` = 2, 2-bit.
  - Beat-counter width `$clog2(BURST_LEN>1 ? BURST_LEN : 2)`.
- One sub-module, `tpseq_counter`: loadable up-counter with terminal-count flag and async active-low clear. It is instantiated twice, once for beats and once for the gap.
- FSM and the datapath gating stay in the top.

## Test plan
- BURST_LEN=4, GAP_CYCLES=3, NUM_BURSTS=2, source counting 0,1,2,… and ready=1: downstream sees 0,1,2,3 (tlast on 3), then 3 idle cycles, then 4,5,6,7 (tlast on 7). `done` pulses once, `burst_count` = 2, then IDLE.
- Same setup with `m_axis_tready` toggling every other cycle: same data sequence, no drops or duplicates. tdata stays stable while tvalid is high and ready is low.
- NUM_BURSTS=0 and `stop` pulsed during beat 1 of burst 3: burst 3 completes all 4 beats, `done` pulses, IDLE, and `burst_count` = 3.
- GAP_CYCLES=0: bursts back-to-back, with beat 0 of the next burst accepted the cycle after the previous tlast.
- `start` and `stop` in the same IDLE cycle → stays IDLE, `gen_enable` 0. `start` during BURST → ignored, with no counter reset.
- `m_axis_aresetn` low mid-burst after 2 beats: all outputs 0 asynchronously, and no `done`. A new `start` then yields a full 4-beat burst.
